// File: rtl/wm8731_i2c_config_seq.sv
// ---------------------------------------------------------------------------
// wm8731_i2c_config_seq
//
// Configures the WM8731 codec over I2C after reset. It walks a fixed table of
// ten register words and sends each one as a 3-byte write:
//   {dev_addr, W}, {reg[6:0], data[8]}, data[7:0]
// A bit-banged single-master engine drives the bus. A NACK stops the word,
// and the word is resent up to max_retries times. If the retries run out,
// error is set (sticky) and the sequence moves on to the next word.
//
// Every SCL/SDA change lands on a quarter-SCL-period tick boundary.
//
// Ports
//   clk_i       system clock, all logic on the rising edge
//   rst_ni      synchronous active-low reset
//   start_i     one-cycle pulse, re-runs the table from IDLE or DONE
//   scl_o       I2C clock, push-pull (no clock stretching)
//   sda_oe_o    1 = pull SDA low, 0 = release (open drain built at board top)
//   sda_in_i    sampled SDA pin level
//   busy_o      sequence in progress
//   ready_o     table completed, held until the next run or reset
//   error_o     sticky, a word exhausted its retries in this run
//   word_idx_o  index of the word currently being sent (0..9)
// ---------------------------------------------------------------------------
module wm8731_i2c_config_seq #(
    parameter int         clk_mhz     = 50,
    parameter int         i2c_khz     = 100,
    parameter logic [6:0] dev_addr    = 7'h1A,
    parameter int         max_retries = 3,
    parameter int         q_cycles    = clk_mhz * 1000 / (4 * i2c_khz)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       scl_o,
    output logic       sda_oe_o,
    input  logic       sda_in_i,
    output logic       busy_o,
    output logic       ready_o,
    output logic       error_o,
    output logic [3:0] word_idx_o
);

    localparam int QW        = (q_cycles > 1) ? $clog2(q_cycles) : 1;
    localparam int RW        = (max_retries > 0) ? $clog2(max_retries + 1) : 1;
    localparam int NUM_WORDS = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_GAP,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [1:0]    byteIdx_q, byteIdx_d;
    logic [3:0]    wordIdx_q, wordIdx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          failed_q, failed_d;
    logic          nack_q, nack_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic          scl_q, scl_d;
    logic          sdaOe_q, sdaOe_d;
    logic [QW-1:0] qCnt_q, qCnt_d;
    logic          autoStart_q;

    logic          busy;
    logic          tick;
    logic          newWord;
    logic [15:0]   curWord;
    logic [7:0]    curByte;

    // Each table entry is {reg[6:0], data[8:0]}, so byte 1 is [15:8] and
    // byte 2 is [7:0]. R8 (sampling control) is left out. Its wanted value
    // 0x000 equals the value the R15 reset leaves behind.
    function automatic logic [15:0] tableWord(input logic [3:0] idx);
        case (idx)
            4'd0:    tableWord = 16'h1E00;  // R15 codec reset
            4'd1:    tableWord = 16'h0017;  // R0 left line in
            4'd2:    tableWord = 16'h0217;  // R1 right line in
            4'd3:    tableWord = 16'h0479;  // R2 left headphone
            4'd4:    tableWord = 16'h0679;  // R3 right headphone
            4'd5:    tableWord = 16'h0812;  // R4 analogue path
            4'd6:    tableWord = 16'h0A00;  // R5 digital path
            4'd7:    tableWord = 16'h0C00;  // R6 power down
            4'd8:    tableWord = 16'h0E02;  // R7 I2S, 16-bit, slave
            4'd9:    tableWord = 16'h1201;  // R9 active
            default: tableWord = 16'h0000;
        endcase
    endfunction

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign tick = busy && (qCnt_q == QW'(q_cycles - 1));

    // Next-state logic. The quarter counter restarts on every tick and is
    // held at zero while idle, so the first tick of a run is a full q_cycles.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bitCnt_d  = bitCnt_q;
        byteIdx_d = byteIdx_q;
        wordIdx_d = wordIdx_q;
        retry_d   = retry_q;
        failed_d  = failed_q;
        nack_d    = nack_q;
        ready_d   = ready_q;
        error_d   = error_q;
        newWord   = 1'b0;
        qCnt_d    = (tick || !busy) ? '0 : qCnt_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i || autoStart_q) begin
                    newWord   = 1'b1;
                    wordIdx_d = 4'd0;
                    retry_d   = '0;
                    ready_d   = 1'b0;
                    error_d   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (phase_q == 2'd1) begin
                        state_d = S_BIT;
                        phase_d = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (tick) begin
                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        if (bitCnt_q == 3'd0) begin
                            state_d = S_ACK;
                        end else begin
                            bitCnt_d = bitCnt_q - 3'd1;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            S_ACK: begin
                // SDA is captured in the last cycle of t2, with SCL high.
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd2) begin
                        nack_d = sda_in_i;
                    end
                    if (phase_q == 2'd3) begin
                        if (nack_q) begin
                            state_d  = S_STOP;
                            failed_d = 1'b1;
                        end else if (byteIdx_q == 2'd2) begin
                            state_d = S_STOP;
                        end else begin
                            state_d   = S_BIT;
                            byteIdx_d = byteIdx_q + 2'd1;
                            bitCnt_d  = 3'd7;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (phase_q == 2'd2) begin
                        state_d = S_GAP;
                        phase_d = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (failed_q && (retry_q < RW'(max_retries))) begin
                            retry_d = retry_q + 1'b1;
                            newWord = 1'b1;
                        end else begin
                            retry_d = '0;
                            if (failed_q) begin
                                error_d = 1'b1;
                            end
                            if (wordIdx_q == 4'(NUM_WORDS - 1)) begin
                                state_d = S_DONE;
                                ready_d = 1'b1;
                            end else begin
                                wordIdx_d = wordIdx_q + 4'd1;
                                newWord   = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (newWord) begin
            state_d   = S_START;
            phase_d   = 2'd0;
            byteIdx_d = 2'd0;
            bitCnt_d  = 3'd7;
            failed_d  = 1'b0;
            nack_d    = 1'b0;
        end
    end

    // Bus levels are computed from the next state, so the registered pins
    // change on the same edge as the state and stay put for the whole tick.
    // Where a phase does not set a level, the previous level is kept.
    always_comb begin
        curWord = tableWord(wordIdx_d);
        case (byteIdx_d)
            2'd0:    curByte = {dev_addr, 1'b0};
            2'd1:    curByte = curWord[15:8];
            default: curByte = curWord[7:0];
        endcase

        scl_d   = scl_q;
        sdaOe_d = sdaOe_q;
        case (state_d)
            S_START: begin
                scl_d   = 1'b1;
                sdaOe_d = (phase_d == 2'd1);
            end
            S_BIT: begin
                case (phase_d)
                    2'd0:    scl_d   = 1'b0;
                    2'd1:    sdaOe_d = ~curByte[bitCnt_d];
                    default: scl_d   = 1'b1;
                endcase
            end
            S_ACK: begin
                case (phase_d)
                    2'd0:    scl_d   = 1'b0;
                    2'd1:    sdaOe_d = 1'b0;
                    default: scl_d   = 1'b1;
                endcase
            end
            S_STOP: begin
                case (phase_d)
                    2'd0: begin
                        scl_d   = 1'b0;
                        sdaOe_d = 1'b1;
                    end
                    2'd1:    scl_d   = 1'b1;
                    default: sdaOe_d = 1'b0;
                endcase
            end
            default: begin
                scl_d   = 1'b1;
                sdaOe_d = 1'b0;
            end
        endcase
    end

    // autoStart_q is set only by reset, so the table runs once on its own
    // in the first cycle after reset is released.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            phase_q     <= 2'd0;
            bitCnt_q    <= 3'd7;
            byteIdx_q   <= 2'd0;
            wordIdx_q   <= 4'd0;
            retry_q     <= '0;
            failed_q    <= 1'b0;
            nack_q      <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            scl_q       <= 1'b1;
            sdaOe_q     <= 1'b0;
            qCnt_q      <= '0;
            autoStart_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bitCnt_q    <= bitCnt_d;
            byteIdx_q   <= byteIdx_d;
            wordIdx_q   <= wordIdx_d;
            retry_q     <= retry_d;
            failed_q    <= failed_d;
            nack_q      <= nack_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            scl_q       <= scl_d;
            sdaOe_q     <= sdaOe_d;
            qCnt_q      <= qCnt_d;
            autoStart_q <= 1'b0;
        end
    end

    assign scl_o      = scl_q;
    assign sda_oe_o   = sdaOe_q;
    assign busy_o     = busy;
    assign ready_o    = ready_q;
    assign error_o    = error_q;
    assign word_idx_o = wordIdx_q;

endmodule
